// File: rtl/cache_mem_adapter_if.sv
// Word-wide main-memory port of cache_mem_adapter: beat request/accept and in-order read return.
interface cache_mem_adapter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WORD_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [WORD_W-1:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata, input m_ready, m_rvalid, m_rdata);
  modport slave  (input m_req, m_we, m_addr, m_wdata, output m_ready, m_rvalid, m_rdata);
endinterface

// File: rtl/cache_mem_adapter.sv
// Line-to-burst adapter between cache_control and a word-wide memory port.
// Optional watchdog abort enabled by defining CACHE_MEM_TIMEOUT_EN.
module cache_mem_adapter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_read_i,
  input  logic                         mem_write_i,
  input  logic [ADDR_W-1:0]            line_addr_i,
  input  logic [LINE_WORDS*WORD_W-1:0] wline_i,
  output logic [LINE_WORDS*WORD_W-1:0] rline_o,
  output logic                         ca_resp_o,
  output logic                         err_o,
  cache_mem_adapter_if.master          mem
);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t                            state_q;
  logic [ADDR_W-1:0]                 base_q;
  logic [CNT_W-1:0]                  issue_q;
  logic [CNT_W-1:0]                  ret_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0] wbuf_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0] rline_q;
  logic                              ca_resp_q;
  logic                              m_req_q;
  logic                              m_we_q;
  logic [ADDR_W-1:0]                 m_addr_q;
  logic [WORD_W-1:0]                 m_wdata_q;

  logic [ADDR_W-1:0] aligned_c;
  logic [ADDR_W-1:0] next_addr_c;
  logic [CNT_W-1:0]  issue_d;
  logic [CNT_W-1:0]  ret_d;
  logic              accept_c;
  logic              rd_ret_c;
  logic              addr_lsb_unused;

  assign aligned_c       = {line_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign addr_lsb_unused = ^line_addr_i[OFF_W-1:0];
  assign accept_c        = m_req_q & mem.m_ready;
  assign rd_ret_c        = (state_q == RD) & mem.m_rvalid;
  assign issue_d         = issue_q + CNT_W'(1);
  assign ret_d           = ret_q + CNT_W'(1);
  assign next_addr_c     = base_q + (ADDR_W'(issue_d) << 2);

`ifdef CACHE_MEM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            stall_c;
  logic            expire_c;

  // A burst cycle with neither an accepted beat nor a read return counts toward the abort.
  assign stall_c  = ((state_q == WR) | (state_q == RD)) & ~accept_c & ~rd_ret_c;
  assign expire_c = stall_c & (wd_q == WD_W'(TIMEOUT - 1));
  assign err_o    = err_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign err_o          = 1'b0;
`endif

  assign rline_o      = rline_q;
  assign ca_resp_o    = ca_resp_q;
  assign mem.m_req    = m_req_q;
  assign mem.m_we     = m_we_q;
  assign mem.m_addr   = m_addr_q;
  assign mem.m_wdata  = m_wdata_q;

  // Burst FSM; every memory-side output is a register, so nothing combinational reaches m_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      issue_q   <= '0;
      ret_q     <= '0;
      wbuf_q    <= '0;
      rline_q   <= '0;
      ca_resp_q <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
`ifdef CACHE_MEM_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ca_resp_q <= 1'b0;
          if (mem_write_i) begin
            state_q   <= WR;
            base_q    <= aligned_c;
            wbuf_q    <= wline_i;
            issue_q   <= '0;
            ret_q     <= '0;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b1;
            m_addr_q  <= aligned_c;
            m_wdata_q <= wline_i[WORD_W-1:0];
          end else if (mem_read_i) begin
            state_q  <= RD;
            base_q   <= aligned_c;
            issue_q  <= '0;
            ret_q    <= '0;
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= aligned_c;
          end
        end
        WR: begin
          if (accept_c) begin
            issue_q <= issue_d;
            if (issue_q == LAST_BEAT) begin
              state_q   <= RESP;
              m_req_q   <= 1'b0;
              m_we_q    <= 1'b0;
              ca_resp_q <= 1'b1;
            end else begin
              m_addr_q  <= next_addr_c;
              m_wdata_q <= wbuf_q[issue_d[IDX_W-1:0]];
            end
          end
        end
        RD: begin
          if (accept_c) begin
            issue_q <= issue_d;
            if (issue_q == LAST_BEAT) m_req_q  <= 1'b0;
            else                      m_addr_q <= next_addr_c;
          end
          // Returns arrive in order, so ret_q is the destination word index.
          if (rd_ret_c) begin
            rline_q[ret_q[IDX_W-1:0]] <= mem.m_rdata;
            ret_q                     <= ret_d;
            if (ret_q == LAST_BEAT) begin
              state_q   <= RESP;
              m_req_q   <= 1'b0;
              ca_resp_q <= 1'b1;
            end
          end
        end
        RESP: begin
          ca_resp_q <= 1'b0;
          state_q   <= IDLE;
`ifdef CACHE_MEM_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
`ifdef CACHE_MEM_TIMEOUT_EN
      if (!stall_c) begin
        wd_q <= '0;
      end else if (expire_c) begin
        wd_q      <= '0;
        state_q   <= RESP;
        m_req_q   <= 1'b0;
        m_we_q    <= 1'b0;
        ca_resp_q <= 1'b1;
        err_q     <= 1'b1;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_cache_mem_adapter.sv
// Bench for cache_mem_adapter: transaction-level model, bench-side memory, per-cycle compare.
module tb_cache_mem_adapter;
  localparam int unsigned LW     = 8;
  localparam int unsigned WW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned TO     = 16;
  localparam int unsigned LINE_W = LW * WW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read;
  logic              mem_write;
  logic [AW-1:0]     line_addr;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rline;
  logic              ca_resp;
  logic              err;

  cache_mem_adapter_if #(.ADDR_W(AW), .WORD_W(WW)) mif ();

  cache_mem_adapter #(.LINE_WORDS(LW), .WORD_W(WW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .line_addr_i(line_addr), .wline_i(wline), .rline_o(rline), .ca_resp_o(ca_resp),
    .err_o(err), .mem(mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- bench memory ----------------
  logic [WW-1:0] mem_ovr [logic [AW-1:0]];

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(LW * 4 - 1);
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [AW-1:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LW; i++) l[i*WW +: WW] = mem_word(base + AW'(4 * i));
    return l;
  endfunction

  typedef struct { logic [AW-1:0] a; int due; } pend_t;
  pend_t pend[$];
  int    last_due;
  int    ready_mode = 0;
  int    lat = 1;
  int    stall_from = -100;
  bit    noise = 0;

  typedef struct { bit rd; bit to; logic [AW-1:0] base; logic [LINE_W-1:0] line; int req; } txn_t;
  txn_t txq[$];

  always @(negedge clk) begin : mem_accept
    pend_t p;
    if (!rst_n) begin
      pend.delete();
      last_due = 0;
    end else if (mif.m_req && mif.m_ready && !mif.m_we) begin
      p.a   = mif.m_addr;
      p.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = p.due;
      pend.push_back(p);
    end
  end

  always @(posedge clk) begin : mem_drive
    pend_t pd;
    #1;
    case (ready_mode)
      0:       mif.m_ready = 1'b1;
      1:       mif.m_ready = ($urandom_range(0, 99) < 70);
      default: mif.m_ready = 1'b0;
    endcase
    if (cyc >= stall_from && cyc < stall_from + 3) mif.m_ready = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      pd = pend.pop_front();
      mif.m_rvalid = 1'b1;
      mif.m_rdata  = mem_word(pd.a);
    end else if (noise && (txq.size() == 0 || !txq[0].rd) && $urandom_range(0, 3) == 0) begin
      mif.m_rvalid = 1'b1;
      mif.m_rdata  = $urandom;
    end else begin
      mif.m_rvalid = 1'b0;
      mif.m_rdata  = $urandom;
    end
  end

  // ---------------- transaction model and per-cycle compare ----------------
  typedef struct { bit we; logic [AW-1:0] a; logic [WW-1:0] d; int c; } beat_t;
  beat_t blog[$];
  int    nbeat, nret, resp_due, last_resp;

  always @(negedge clk) begin : model_chk
    bit    have;
    bit    exp_req;
    bit    exp_resp;
    int    start;
    int    due;
    txn_t  f;
    beat_t b;
    if (!rst_n) begin
      txq.delete();
      nbeat = 0; nret = 0; resp_due = -1; last_resp = -100;
    end else begin
      have  = txq.size() > 0;
      start = 0;
      due   = -1;
      if (have) begin
        f     = txq[0];
        start = (f.req > last_resp + 1) ? f.req : last_resp + 1;
        due   = f.to ? start + TO + 1 : resp_due;
      end
      exp_req = have && cyc > start && nbeat < LW && !(due >= 0 && cyc >= due);
      chk("m_req", LINE_W'(mif.m_req), LINE_W'(exp_req));
      if (mif.m_req && exp_req) begin
        chk("m_we", LINE_W'(mif.m_we), LINE_W'(!f.rd));
        chk("m_addr", LINE_W'(mif.m_addr), LINE_W'(f.base + AW'(4 * nbeat)));
        if (!f.rd) chk("m_wdata", LINE_W'(mif.m_wdata), LINE_W'(f.line[nbeat*WW +: WW]));
        if (mif.m_ready) begin
          b.we = mif.m_we; b.a = mif.m_addr; b.d = mif.m_wdata; b.c = cyc;
          blog.push_back(b);
          nbeat++;
          if (!f.rd && nbeat == LW) resp_due = cyc + 1;
        end
      end
      if (have && f.rd && !f.to && cyc > start && mif.m_rvalid && nret < LW) begin
        nret++;
        if (nret == LW) resp_due = cyc + 1;
      end
      if (have) due = f.to ? start + TO + 1 : resp_due;
      exp_resp = have && due == cyc;
      chk("ca_resp", LINE_W'(ca_resp), LINE_W'(exp_resp));
      if (exp_resp) begin
        chk("err", LINE_W'(err), LINE_W'(f.to));
        if (f.rd && !f.to) chk("rline", rline, f.line);
        void'(txq.pop_front());
        nbeat = 0; nret = 0; resp_due = -1; last_resp = cyc;
      end
    end
  end

  // ---------------- cache_control side ----------------
  task automatic wait_resp(output int rc);
    rc = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (ca_resp) begin rc = cyc; break; end
    end
    if (rc < 0) begin
      total++; bad++;
      $display("FAIL resp_wait: no ca_resp within bound at cycle %0d", cyc);
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk); #2 rst_n = 1'b1;
    end
  endtask

  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [LINE_W-1:0] wl, input bit to,
                        output int rq, output int r1, output int r2);
    txn_t t;
    @(posedge clk); #1;
    rq = cyc; r2 = -1;
    if (wr) begin
      t.rd = 0; t.to = 0; t.base = align(addr); t.line = wl; t.req = cyc;
      txq.push_back(t);
    end
    if (rd) begin
      t.rd = 1; t.to = to; t.base = align(addr); t.line = mem_line(align(addr)); t.req = cyc;
      txq.push_back(t);
    end
    mem_write = wr; mem_read = rd; line_addr = addr; wline = wl;
    wait_resp(r1);
    @(posedge clk); #1;
    mem_write = 1'b0;
    if (!(wr && rd)) mem_read = 1'b0;
    if (wr && rd) begin
      wait_resp(r2);
      @(posedge clk); #1;
      mem_read = 1'b0;
    end
  endtask

  initial begin : global_bound
    #600000;
    $display("FAIL global_bound: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int                rq, r1, r2;
    txn_t              t;
    logic [LINE_W-1:0] wl;
    int                op;
    mem_read = 1'b0; mem_write = 1'b0; line_addr = '0; wline = '0;
    repeat (3) @(negedge clk);
    chk("rst m_req", LINE_W'(mif.m_req), '0);
    chk("rst m_we", LINE_W'(mif.m_we), '0);
    chk("rst m_addr", LINE_W'(mif.m_addr), '0);
    chk("rst m_wdata", LINE_W'(mif.m_wdata), '0);
    chk("rst ca_resp", LINE_W'(ca_resp), '0);
    chk("rst err", LINE_W'(err), '0);
    chk("rst rline", rline, '0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write-back of 0xA0..0xA7 from an unaligned address.
    blog.delete();
    wl = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
    do_req(1'b1, 1'b0, 32'h1000_001C, wl, 1'b0, rq, r1, r2);
    chk("wb resp cycle", LINE_W'(r1 - rq), LINE_W'(9));
    chk("wb beat count", LINE_W'(blog.size()), LINE_W'(8));
    if (blog.size() == 8) begin
      chk("wb first addr", LINE_W'(blog[0].a), LINE_W'(32'h1000_0000));
      chk("wb first data", LINE_W'(blog[0].d), LINE_W'(32'hA0));
      chk("wb last addr", LINE_W'(blog[7].a), LINE_W'(32'h1000_001C));
      chk("wb last data", LINE_W'(blog[7].d), LINE_W'(32'hA7));
      chk("wb first beat cycle", LINE_W'(blog[0].c - rq), LINE_W'(1));
      chk("wb last beat cycle", LINE_W'(blog[7].c - rq), LINE_W'(8));
    end

    // Fill with latency 3 returning 0xB0..0xB7.
    for (int i = 0; i < LW; i++) mem_ovr[32'h2000_0040 + 32'(4 * i)] = 32'hB0 + 32'(i);
    lat = 3;
    do_req(1'b0, 1'b1, 32'h2000_0040, '0, 1'b0, rq, r1, r2);
    chk("fill resp cycle", LINE_W'(r1 - rq), LINE_W'(12));
    chk("fill rline", rline,
        256'h000000B7_000000B6_000000B5_000000B4_000000B3_000000B2_000000B1_000000B0);

    // Three-cycle stall on beat 2 of a write.
    blog.delete();
    stall_from = cyc + 4;
    do_req(1'b1, 1'b0, 32'h3000_0100, wl, 1'b0, rq, r1, r2);
    stall_from = -100;
    chk("stall resp cycle", LINE_W'(r1 - rq), LINE_W'(12));
    if (blog.size() == 8) chk("stall beat2 cycle", LINE_W'(blog[2].c - rq), LINE_W'(6));

    // Simultaneous write and read: write first, then the held read.
    lat = 2;
    do_req(1'b1, 1'b1, 32'h4000_0020, ~wl, 1'b0, rq, r1, r2);
    chk("both write resp", LINE_W'(r1 - rq), LINE_W'(9));
    chk("both read resp", LINE_W'(r2 - r1), LINE_W'(12));

    // Reset in the middle of a fill, after four returns.
    lat = 1;
    @(posedge clk); #1;
    t.rd = 1; t.to = 0; t.base = 32'h5000_0000; t.line = mem_line(32'h5000_0000); t.req = cyc;
    txq.push_back(t);
    mem_read = 1'b1; line_addr = 32'h5000_0000;
    for (int i = 0; i < 100 && nret < 4; i++) begin @(negedge clk); #1; end
    chk("pre-reset returns", LINE_W'(nret), LINE_W'(4));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort m_req", LINE_W'(mif.m_req), '0);
    chk("abort rline", rline, '0);
    chk("abort ca_resp", LINE_W'(ca_resp), '0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_req(1'b0, 1'b1, 32'h5000_0000, '0, 1'b0, rq, r1, r2);
    chk("refill resp cycle", LINE_W'(r1 - rq), LINE_W'(10));

`ifdef CACHE_MEM_TIMEOUT_EN
    ready_mode = 2;
    do_req(1'b0, 1'b1, 32'h6000_0000, '0, 1'b1, rq, r1, r2);
    chk("timeout resp cycle", LINE_W'(r1 - rq), LINE_W'(17));
    ready_mode = 0;
    repeat (4) @(negedge clk);
`endif

    // Randomized traffic with backpressure, varying latency and stray returns.
    noise = 1;
    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 1);
      lat        = $urandom_range(1, 4);
      op         = $urandom_range(0, 2);
      for (int i = 0; i < LW; i++) wl[i*WW +: WW] = $urandom;
      do_req(op != 1, op != 0, $urandom, wl, 1'b0, rq, r1, r2);
    end
    noise = 0;
    ready_mode = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_adapter.md
# cache_mem_adapter

Memory-side stage directly downstream of `cache_control`. Turns the controller's line-level `mem_read`/`mem_write` requests into word-wide bursts on the main-memory port, assembles returned words into a full line, and answers with a one-cycle `ca_resp`. It buffers the line address and write-back line, so the cache arrays are free while the burst runs.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per cache line; power of two, ≥2.
- `WORD_W`, 32: memory word width in bits.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 1024: watchdog limit in cycles (used only with `CACHE_MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: line fill request from `cache_control`; held until `ca_resp`.
- `mem_write` in 1: line write-back request; held until `ca_resp`.
- `line_addr` in ADDR_W: line byte address; low log2(LINE_WORDS)+2 bits ignored.
- `wline` in LINE_WORDS*WORD_W: write-back line; word i is bits [i*WORD_W +: WORD_W].
- `rline` out LINE_WORDS*WORD_W: filled line; valid while `ca_resp`=1 and held until the next fill.
- `ca_resp` out 1: one-cycle completion pulse.
- `err` out 1: aborted transaction, valid with `ca_resp`.
- `m_req` out 1: beat request.
- `m_we` out 1: beat is a write.
- `m_addr` out ADDR_W: beat byte address.
- `m_wdata` out WORD_W: write beat data.
- `m_ready` in 1: memory accepts a beat when `m_req && m_ready`.
- `m_rvalid` in 1: read data return, in order, one word per cycle.
- `m_rdata` in WORD_W: read return data.

## Operation
- States are IDLE, WR, RD, RESP.
- In IDLE, `mem_write` has priority: latch `line_addr` (aligned) and `wline`, clear beat counters, go to WR. Otherwise, `mem_read` latches the address and goes to RD.
- If both requests are high, the write is served first. The read stays asserted and is taken after RESP returns to IDLE.
- WR:
  - `m_req=1`, `m_we=1`, `m_addr = base + 4*issue_cnt`, `m_wdata = word[issue_cnt]`.
  - `issue_cnt` increments on each accepted beat.
  - After beat LINE_WORDS-1 is accepted, go to RESP.
- RD:
  - `m_req=1`, `m_we=0` while `issue_cnt < LINE_WORDS`; then `m_req=0`.
  - Each `m_rvalid` writes `m_rdata` into `rline` word `ret_cnt` and increments `ret_cnt`.
  - Issue and return can occur in the same cycle.
  - When return LINE_WORDS-1 is captured, go to RESP.
- RESP: `ca_resp=1` for exactly one cycle, then IDLE.
- `m_rvalid` outside RD is ignored.
- Counters are log2(LINE_WORDS)+1 bits wide. Addresses wrap modulo 2^ADDR_W.
- Reset values: state IDLE, all counters 0, `rline` 0, and `ca_resp`, `err`, `m_req`, `m_we`, `m_addr`, `m_wdata` all 0.
- Reset mid-burst aborts immediately. `m_req` drops asynchronously, no `ca_resp` is issued, and partial `rline` contents are cleared.

## Timing
- Request sampled in IDLE at cycle 0. First `m_req` is in cycle 1; there is no combinational path from `mem_*` to `m_*`.
- Write with `m_ready` always 1: beats in cycles 1..LINE_WORDS, `ca_resp` in cycle LINE_WORDS+1.
- Read with `m_ready`=1 and fixed memory latency L (rvalid L cycles after acceptance): `ca_resp` in cycle LINE_WORDS+L+1.
- `m_ready`=0 stalls the beat. `m_addr`, `m_wdata` and `m_we` are held stable while `m_req`=1 and unaccepted.
- `cache_control` drops its request in the cycle after `ca_resp`, and IDLE samples it again one cycle later. A held request therefore cannot retrigger.

## Configuration
- `CACHE_MEM_TIMEOUT_EN` defined:
  - A watchdog counts consecutive WR/RD cycles with no accepted beat and no `m_rvalid`.
  - When the count reaches TIMEOUT, go to RESP with `err=1`, drop `m_req`, and leave `rline` unchanged.
  - The watchdog clears on any progress.
- Not defined: no watchdog logic, `err` tied to 0, and bursts wait indefinitely.

## Test plan
- Write-back, LINE_WORDS=8, `line_addr`=0x1000_001C, `wline` words 0..7 = 0xA0..0xA7, `m_ready`=1 → beats at 0x1000_0000..0x1000_001C with data 0xA0..0xA7 in cycles 1..8, `ca_resp` in cycle 9, `err`=0.
- Fill, `line_addr`=0x2000_0040, memory returns 0xB0..0xB7 with L=3 → 8 read beats in cycles 1..8, `ca_resp` in cycle 12, `rline` words = 0xB0..0xB7.
- Backpressure: write with `m_ready` low for 3 cycles on beat 2 → `m_addr`/`m_wdata` stable at beat 2 throughout the stall, `ca_resp` in cycle 12.
- Simultaneous `mem_read`=`mem_write`=1 → full write burst and `ca_resp`, then IDLE, then a full read burst and a second `ca_resp`.
- `rst_n` low during RD after 4 returns → `m_req`=0 immediately, `rline`=0, no `ca_resp`; the next fill completes normally.
- With `CACHE_MEM_TIMEOUT_EN` and TIMEOUT=16: fill with `m_ready` held 0 → `ca_resp`=1 and `err`=1 in cycle 17, `m_req`=0 afterwards.
